m68k_bus_master: RTL

M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

---
 rtl/m68k_bus_master.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/m68k_bus_master.sv
// m68k_bus_master
// Single-master 68000-style asynchronous bus cycle engine. A request is
// latched in IDLE and driven on the bus through ADDR/ASSERT/WAIT/DATA, then
// completion is reported with a one-cycle DONE pulse in END. The WAIT state
// counts nDTACK-high samples and ends the cycle with a bus error once the
// count reaches TIMEOUT. All bus and status outputs decode from registered
// state (Moore), so strobes release immediately when nRESET falls.

module m68k_bus_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK_68KCLK,
    input  logic        nRESET,

    input  logic        REQ,
    input  logic        RW,
    input  logic [22:0] ADDR,
    input  logic [1:0]  BE,
    input  logic [15:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] RDATA,

    output logic [22:0] A,
    output logic        BUS_RW,
    output logic        nAS,
    output logic        nUDS,
    output logic        nLDS,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    input  logic [15:0] D_IN,
    input  logic        nDTACK
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_ASSERT = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_END    = 3'd5;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [2:0]  state;
    logic [2:0]  state_nxt;

    logic [22:0] addr_q;
    logic        rw_q;
    logic [1:0]  be_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        err_q;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_inc;

    logic        req_ok;
    logic        req_bad;
    logic        bus_active;
    logic        wait_expired;

    assign req_ok       = (state == ST_IDLE) && REQ && (BE != 2'b00);
    assign req_bad      = (state == ST_IDLE) && REQ && (BE == 2'b00);
    assign wait_cnt_inc = wait_cnt + 8'd1;
    assign wait_expired = (wait_cnt_inc == TIMEOUT_C);

    // Next-state decode; nDTACK only influences the WAIT transition
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_ok) begin
                    state_nxt = ST_ADDR;
                end else if (req_bad) begin
                    state_nxt = ST_END;
                end
            end
            ST_ADDR:   state_nxt = ST_ASSERT;
            ST_ASSERT: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!nDTACK) begin
                    state_nxt = ST_DATA;
                end else if (wait_expired) begin
                    state_nxt = ST_END;
                end
            end
            ST_DATA:   state_nxt = ST_END;
            ST_END:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any cycle in flight without a DONE pulse
    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the request on the accepting edge; held through END and beyond
    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            addr_q  <= '0;
            rw_q    <= 1'b1;
            be_q    <= 2'b00;
            wdata_q <= '0;
        end else if (req_ok) begin
            addr_q  <= ADDR;
            rw_q    <= RW;
            be_q    <= BE;
            wdata_q <= WDATA;
        end
    end

    // Wait counter: cleared in ASSERT, counts nDTACK-high samples in WAIT
    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            wait_cnt <= '0;
        end else if (state == ST_ASSERT) begin
            wait_cnt <= '0;
        end else if ((state == ST_WAIT) && nDTACK) begin
            wait_cnt <= wait_cnt_inc;
        end
    end

    // Completion status: only a path through DATA ends without error
    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            err_q <= 1'b0;
        end else if ((state_nxt == ST_END) && (state != ST_END)) begin
            err_q <= (state != ST_DATA);
        end
    end

    // Read data is sampled from the bus as the cycle leaves DATA
    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            rdata_q <= '0;
        end else if ((state == ST_DATA) && rw_q) begin
            rdata_q <= D_IN;
        end
    end

    assign bus_active = (state == ST_ASSERT) || (state == ST_WAIT) || (state == ST_DATA);

    assign BUSY   = (state != ST_IDLE);
    assign DONE   = (state == ST_END);
    assign ERR    = (state == ST_END) && err_q;
    assign RDATA  = rdata_q;

    assign A      = addr_q;
    assign BUS_RW = (state == ST_IDLE) ? 1'b1 : rw_q;
    assign nAS    = !bus_active;
    assign nUDS   = !(bus_active && be_q[1]);
    assign nLDS   = !(bus_active && be_q[0]);
    assign D_OUT  = wdata_q;
    assign D_OE   = bus_active && !rw_q;

endmodule
